muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit holding the architectural HI/LO registers for the MIPS core.
- Executes MULT, MULTU, DIV, DIVU (multi-cycle) and MTHI, MTLO (single-cycle).
- hi and lo outputs feed the writeback-select mux4 (MFHI/MFLO path).
- Stall logic uses busy to hold the pipeline on HI/LO reads or new muldiv ops while an operation is in flight.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  operation request; accepted only on a rising edge where busy==0
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
a  input  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data
b  input  WIDTH  rt operand: multiplier or divisor
busy  output  1  high while a multi-cycle operation is in flight
done  output  1  one-cycle pulse; HI/LO hold a new multi-cycle result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE; hi, lo and the iteration counter clear to 0.
  - busy=0 and done=0 from the next cycle.
  - rst overrides start in the same cycle.
- States:
  - IDLE: busy=0. Accept start here only.
  - CALC: busy=1, 32 iterations, one per cycle.
  - FIX: busy=1, one cycle of sign correction, then writes HI/LO.
- Accept (state IDLE, start=1 at edge E):
  - op 0-3: latch a and b. Record operand signs for the signed ops (0, 2); store magnitudes. Enter CALC with counter=0.
  - op 4 (MTHI): hi<=a at edge E; stay IDLE; no done.
  - op 5 (MTLO): lo<=a at edge E; stay IDLE; no done.
  - op 6/7: no state change, no done.
  - start while busy=1 is ignored entirely. Upstream must hold the request until busy==0.
- CALC:
  - Multiply: radix-2 shift-add on magnitudes into a 64-bit accumulator.
  - Divide: restoring division on magnitudes into a 32-bit quotient and remainder.
  - Counter increments each cycle. After the 32nd CALC cycle (edge E+32) the state moves to FIX.
- FIX (edge E+33):
  - Apply sign correction and write hi/lo.
  - Return to IDLE; done=1 for exactly the cycle after E+33.
  - busy is high for cycles E+1..E+33, i.e. 33 cycles.
  - New hi/lo are visible in the same cycle done is high.
- Results:
  - MULT/MULTU: {hi,lo} = full 64-bit product. MULT is the two's-complement signed product.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - DIV truncates toward zero; the remainder takes the dividend's sign.
  - Divide by zero (b==0, DIV or DIVU): lo=0xFFFFFFFF and hi=a, still after the full 33-cycle latency.
  - DIV overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No exception.
- During CALC/FIX, hi and lo keep their previous values. No partial results are visible.
- rst during CALC or FIX: the operation is abandoned, hi/lo=0, and done does not pulse.
- Widths:
  - Magnitude of 0x80000000 is treated as the unsigned value 2^31. No overflow in the abs step.
  - The 64-bit negate is a two's complement across the full 64 bits.

Test Plan:
1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high 33 cycles, done pulses once; hi=0xFFFFFFFE, lo=0x00000001.
2. MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=0x00000064 after 33 busy cycles. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on the next cycle -> each register updates on its accepting edge; busy and done stay 0. Then a DIVU 17/5 issued at E, and MTHI 0xDEADBEEF held with start=1 through E+1..E+33 -> the MTHI is ignored for those cycles. Final values after done: lo=3, hi=2. Since start is still asserted when busy drops, the MTHI is accepted on the first IDLE edge and then hi=0xDEADBEEF.
5. DIVU 1000/7 started, rst=1 at CALC iteration 10 -> next cycle busy=0, hi=lo=0, no done. A new MULTU 6*7 then completes with lo=42, hi=0.
6. op=6 with start=1 while idle -> no change to hi/lo, busy and done stay 0. Back-to-back MULTU issued on the cycle done pulses -> accepted, busy re-asserts next cycle.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take 33 busy cycles (32 iterations + 1 sign fix);
// MTHI/MTLO write in the accepting cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned DW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [DW-1:0]      r_acc;      // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   r_opnd;     // multiplicand or divisor magnitude
  logic               r_is_div;
  logic               r_neg_q;    // product / quotient must be negated
  logic               r_neg_r;    // remainder must be negated (dividend sign)
  logic               r_div0;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;

  logic               w_accept;
  logic               w_signed;
  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [DW-1:0]      w_mul_acc;
  logic [WIDTH:0]     w_div_shift;
  logic               w_div_ok;
  logic [WIDTH-1:0]   w_div_diff;
  logic [DW-1:0]      w_div_acc;
  logic [DW-1:0]      w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

  // Operand capture: signs for signed ops, magnitudes (0x80000000 -> 2^31 unsigned)
  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign w_sign_a = w_signed && i_a[WIDTH-1];
  assign w_sign_b = w_signed && i_b[WIDTH-1];
  assign w_mag_a  = w_sign_a ? (WIDTH'(0) - i_a) : i_a;
  assign w_mag_b  = w_sign_b ? (WIDTH'(0) - i_b) : i_b;

  // Shift-add multiply step: add multiplicand to upper half when LSB set, shift right
  assign w_mul_sum = {1'b0, r_acc[DW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : (WIDTH+1)'(0));
  assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide step: shift next dividend bit into remainder, trial subtract
  assign w_div_shift = {r_acc[DW-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_ok    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;
  assign w_div_acc   = w_div_ok ? {w_div_diff, r_acc[WIDTH-2:0], 1'b1}
                                : {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  // Sign correction applied in FIX
  assign w_prod   = r_neg_q ? (DW'(0) - r_acc) : r_acc;
  assign w_quo    = r_div0  ? {WIDTH{1'b1}}
                            : (r_neg_q ? (WIDTH'(0) - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0]);
  assign w_rem    = r_neg_r ? (WIDTH'(0) - r_acc[DW-1:WIDTH]) : r_acc[DW-1:WIDTH];
  assign w_fix_hi = r_is_div ? w_rem : w_prod[DW-1:WIDTH];
  assign w_fix_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_start && !i_op[2]) w_state_nxt = S_CALC;
      S_CALC: if (r_cnt == CNT_W'(WIDTH - 1)) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath, HI/LO and status registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (i_op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                r_cnt    <= '0;
                r_is_div <= i_op[1];
                r_neg_q  <= w_sign_a ^ w_sign_b;
                r_neg_r  <= w_sign_a;
                r_div0   <= (i_b == WIDTH'(0));
                r_acc    <= i_op[1] ? {WIDTH'(0), w_mag_a} : {WIDTH'(0), w_mag_b};
                r_opnd   <= i_op[1] ? w_mag_b : w_mag_a;
              end
              OP_MTHI: r_hi <= i_a;
              OP_MTLO: r_lo <= i_a;
              default: ;
            endcase
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_acc <= r_is_div ? w_div_acc : w_mul_acc;
        end
        S_FIX: begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops
// checked against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_start(start),
    .i_op   (op),
    .i_a    (a),
    .i_b    (b),
    .o_busy (busy),
    .o_done (done),
    .o_hi   (hi),
    .o_lo   (lo)
  );

  always #5 clk = ~clk;

  // Reference model: MIPS HI/LO semantics with plain 64-bit arithmetic
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                inout logic [31:0] h, inout logic [31:0] l);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = 64'(sx * sy); h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = {32'd0, x} * {32'd0, y}; h = p[63:32]; l = p[31:0]; end
      3'd2: begin
        if (y == 32'd0) begin l = 32'hFFFF_FFFF; h = x; end
        else begin q = sx / sy; r = sx % sy; l = q[31:0]; h = r[31:0]; end
      end
      3'd3: begin
        if (y == 32'd0) begin l = 32'hFFFF_FFFF; h = x; end
        else begin l = x / y; h = x % y; end
      end
      3'd4: h = x;
      3'd5: l = x;
      default: ;
    endcase
  endfunction

  // Issue one multi-cycle op and watch it to completion; returns observations only
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int nbusy, output int ndone, output int nleak,
                        output logic [31:0] rh, output logic [31:0] rl);
    logic [31:0] h0, l0;
    bit got, fin;
    @(negedge clk);
    h0 = hi; l0 = lo;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0; ndone = 0; nleak = 0; got = 0; fin = 0;
    rh = 32'hx; rl = 32'hx;
    for (int k = 0; k < 80 && !fin; k++) begin
      if (busy) begin
        nbusy++;
        if (hi !== h0 || lo !== l0) nleak++;
      end
      if (done) begin
        ndone++;
        if (!got) begin rh = hi; rl = lo; end
        got = 1;
      end else if (got) begin
        fin = 1;
      end
      if (!fin) @(negedge clk);
    end
  endtask

  task automatic drive_one(input logic [2:0] o, input logic [31:0] x);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = 32'h5555_AAAA;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; op = 3'd4; a = 32'hCAFE_F00D; b = 32'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_status busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      failures++; $display("FAIL reset_hilo hi=%h lo=%h required 0 0", hi, lo);
    end
    start = 1'b0; rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  // One directed multi-cycle op with spec-given expected values
  task automatic directed(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    int nb, nd, nl;
    logic [31:0] rh, rl;
    run_op(o, x, y, nb, nd, nl, rh, rl);
    checks++;
    if (nb != 33 || nd != 1) begin
      failures++; $display("FAIL %s_timing busy_cycles=%0d done_pulses=%0d required 33 1", name, nb, nd);
    end
    checks++;
    if (nl != 0) begin
      failures++; $display("FAIL %s_partial hi/lo changed in %0d busy cycles, required 0", name, nl);
    end
    checks++;
    if (rh !== eh || rl !== el) begin
      failures++; $display("FAIL %s_result hi=%h lo=%h required hi=%h lo=%h", name, rh, rl, eh, el);
    end
    m_hi = eh; m_lo = el;
  endtask

  task automatic test_mult();
    directed("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    directed("mult_neg",  3'd0, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB);
  endtask

  task automatic test_div();
    directed("div_neg",   3'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD);
    directed("divu_zero", 3'd3, 32'd100,       32'd0,          32'h0000_0064, 32'hFFFF_FFFF);
    directed("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000);
  endtask

  task automatic test_mt_and_ignore();
    int nbad, nd;
    bit got;
    drive_one(3'd4, 32'h1234_5678);
    checks++;
    if (hi !== 32'h1234_5678 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL mthi hi=%h busy=%b done=%b required 12345678 0 0", hi, busy, done);
    end
    drive_one(3'd5, 32'h9ABC_DEF0);
    checks++;
    if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL mtlo hi=%h lo=%h busy=%b done=%b required 12345678 9abcdef0 0 0",
                           hi, lo, busy, done);
    end
    // DIVU 17/5 with an MTHI held on start throughout the busy window
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd17; b = 32'd5;
    @(negedge clk);
    op = 3'd4; a = 32'hDEAD_BEEF;
    nbad = 0; nd = 0; got = 0;
    for (int k = 0; k < 80 && !got; k++) begin
      if (busy && hi !== 32'h1234_5678) nbad++;
      if (done) begin
        got = 1; nd++;
        checks++;
        if (hi !== 32'd2 || lo !== 32'd3) begin
          failures++; $display("FAIL divu_held_result hi=%h lo=%h required 2 3", hi, lo);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (nbad != 0 || nd != 1) begin
      failures++; $display("FAIL mthi_ignored_while_busy bad_cycles=%0d done=%0d required 0 1", nbad, nd);
    end
    checks++;
    if (hi !== 32'hDEAD_BEEF || lo !== 32'd3 || busy !== 1'b0) begin
      failures++; $display("FAIL mthi_after_idle hi=%h lo=%h busy=%b required deadbeef 3 0", hi, lo, busy);
    end
    start = 1'b0;
    m_hi = 32'hDEAD_BEEF; m_lo = 32'd3;
  endtask

  task automatic test_abort();
    int nd;
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++; $display("FAIL abort_state busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo);
    end
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    checks++;
    if (nd != 0) begin
      failures++; $display("FAIL abort_no_done active_cycles=%0d required 0", nd);
    end
    directed("multu_after_abort", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42);
  endtask

  task automatic test_back_to_back();
    int nb, nd;
    bit got;
    // Reserved ops do nothing
    for (int r = 6; r < 8; r++) begin
      drive_one(3'(r), 32'h0BAD_0BAD);
      nb = 0;
      repeat (3) begin
        if (busy || done) nb++;
        @(negedge clk);
      end
      checks++;
      if (nb != 0 || hi !== m_hi || lo !== m_lo) begin
        failures++; $display("FAIL reserved_op%0d active=%0d hi=%h lo=%h required 0 %h %h",
                             r, nb, hi, lo, m_hi, m_lo);
      end
    end
    // First MULTU; second MULTU issued in the done cycle
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'h0001_0000; b = 32'h0001_0000;
    @(negedge clk);
    start = 1'b0;
    got = 0;
    for (int k = 0; k < 80 && !got; k++) begin
      if (done) got = 1;
      else @(negedge clk);
    end
    checks++;
    if (!got || hi !== 32'd1 || lo !== 32'd0) begin
      failures++; $display("FAIL b2b_first got=%0d hi=%h lo=%h required 1 1 0", got, hi, lo);
    end
    start = 1'b1; op = 3'd1; a = 32'd123456; b = 32'd1000;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL b2b_accept busy=%b done=%b required 1 0", busy, done);
    end
    nd = 0; nb = 0; got = 0;
    for (int k = 0; k < 80 && !got; k++) begin
      if (busy) nb++;
      if (done) got = 1;
      else @(negedge clk);
    end
    checks++;
    if (!got || nb != 33 || hi !== 32'd0 || lo !== 32'd123456000) begin
      failures++; $display("FAIL b2b_second got=%0d busy_cycles=%0d hi=%h lo=%h required 1 33 0 %h",
                           got, nb, hi, lo, 32'd123456000);
    end
    @(negedge clk);
    m_hi = 32'd0; m_lo = 32'd123456000;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corners [5];
    corners[0] = 32'd0;          corners[1] = 32'd1;          corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;  corners[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 20));
    return $urandom;
  endfunction

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x, y, rh, rl;
    int nb, nd, nl;
    for (int n = 0; n < 30; n++) begin
      o = 3'($urandom_range(0, 5));
      x = pick();
      y = pick();
      if (o >= 3'd4) begin
        drive_one(o, x);
        model(o, x, y, m_hi, m_lo);
        checks++;
        if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
          failures++; $display("FAIL rand%0d_mt op=%0d hi=%h lo=%h busy=%b required %h %h 0",
                               n, o, hi, lo, busy, m_hi, m_lo);
        end
      end else begin
        run_op(o, x, y, nb, nd, nl, rh, rl);
        model(o, x, y, m_hi, m_lo);
        checks++;
        if (nb != 33 || nd != 1 || nl != 0 || rh !== m_hi || rl !== m_lo) begin
          failures++; $display("FAIL rand%0d op=%0d a=%h b=%h hi=%h lo=%h busy=%0d done=%0d leak=%0d required hi=%h lo=%h 33 1 0",
                               n, o, x, y, rh, rl, nb, nd, nl, m_hi, m_lo);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_mt_and_ignore();
    test_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
